// File: rtl/hazard_control_unit.sv
// Hazard and stall controller for the five-stage LC-3b pipeline: drives the PC and
// pipeline-register load/flush enables and keeps saturating stall/flush counters.
module hazard_control_unit #(
    parameter int CNT_W   = 16,
    parameter int FLUSH_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [2:0]         id_sr1,
    input  logic [2:0]         id_sr2,
    input  logic               id_uses_sr1,
    input  logic               id_uses_sr2,
    input  logic               ex_valid,
    input  logic               ex_mem_read,
    input  logic               ex_reg_write,
    input  logic [2:0]         ex_dest,
    input  logic               imem_resp,
    input  logic               dmem_req,
    input  logic               dmem_resp,
    input  logic               mem_br_taken,
    input  logic               clr_counters,
    output logic               load_pc,
    output logic               load_if_id,
    output logic               load_id_ex,
    output logic               load_ex_mem,
    output logic               load_mem_wb,
    output logic               flush_if_id,
    output logic               flush_id_ex,
    output logic               flush_ex_mem,
    output logic [1:0]         stall_state,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [FLUSH_W-1:0] flush_count
);

    // state     | meaning
    // RUN       | normal evaluation, no stall in progress
    // LU_BUBBLE | bubble just inserted for a load-use; hazard detection masked
    // DMEM_WAIT | pipeline frozen waiting on the data cache
    typedef enum logic [1:0] {
        RUN       = 2'b00,
        LU_BUBBLE = 2'b01,
        DMEM_WAIT = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic dmem_stall, src_match, lu_hazard, br_win;
    logic ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb;
    logic fl_if_id, fl_id_ex, fl_ex_mem;

    always_comb begin
        dmem_stall = dmem_req & ~dmem_resp;
        src_match  = (id_uses_sr1 && (id_sr1 == ex_dest)) ||
                     (id_uses_sr2 && (id_sr2 == ex_dest));
        lu_hazard  = ex_valid & ex_mem_read & ex_reg_write & id_valid & src_match &
                     (state_q != LU_BUBBLE);

        ld_pc     = 1'b1;
        ld_if_id  = 1'b1;
        ld_id_ex  = 1'b1;
        ld_ex_mem = 1'b1;
        ld_mem_wb = 1'b1;
        fl_if_id  = 1'b0;
        fl_id_ex  = 1'b0;
        fl_ex_mem = 1'b0;
        br_win    = 1'b0;
        state_d   = RUN;

        if (dmem_stall) begin
            ld_pc     = 1'b0;
            ld_if_id  = 1'b0;
            ld_id_ex  = 1'b0;
            ld_ex_mem = 1'b0;
            ld_mem_wb = 1'b0;
            state_d   = DMEM_WAIT;
        end else if (mem_br_taken) begin
            // redirect wins over a pending icache miss: the wrong-path fetch is dropped
            fl_if_id  = 1'b1;
            fl_id_ex  = 1'b1;
            fl_ex_mem = 1'b1;
            br_win    = 1'b1;
        end else if (lu_hazard) begin
            ld_pc     = 1'b0;
            ld_if_id  = 1'b0;
            fl_id_ex  = 1'b1;
            state_d   = LU_BUBBLE;
        end else if (!imem_resp) begin
            ld_pc     = 1'b0;
            fl_if_id  = 1'b1;
        end
    end

    // Reset holds every register and invalidates all pipeline contents.
    always_comb begin
        load_pc      = reset_n & ld_pc;
        load_if_id   = reset_n & ld_if_id;
        load_id_ex   = reset_n & ld_id_ex;
        load_ex_mem  = reset_n & ld_ex_mem;
        load_mem_wb  = reset_n & ld_mem_wb;
        flush_if_id  = ~reset_n | fl_if_id;
        flush_id_ex  = ~reset_n | fl_id_ex;
        flush_ex_mem = ~reset_n | fl_ex_mem;
        stall_state  = state_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (clr_counters) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!ld_pc && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (br_win && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid, id_uses_sr1, id_uses_sr2;
    logic [2:0]  id_sr1, id_sr2, ex_dest;
    logic        ex_valid, ex_mem_read, ex_reg_write;
    logic        imem_resp, dmem_req, dmem_resp, mem_br_taken, clr_counters;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]  stall_state;
    logic [15:0] stall_cycles;
    logic [7:0]  flush_count;

    hazard_control_unit #(.CNT_W(16), .FLUSH_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dest(ex_dest), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .mem_br_taken(mem_br_taken), .clr_counters(clr_counters),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .stall_state(stall_state), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  ld;   // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [2:0]  fl;   // {if_id, id_ex, ex_mem}
        logic [1:0]  st;
        logic [15:0] sc;
        logic [7:0]  fc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    localparam logic [1:0] RUN = 2'b00, LUB = 2'b01, DMW = 2'b10;

    task automatic push(input string nm, input logic [4:0] ld, input logic [2:0] fl,
                        input logic [1:0] st, input logic [15:0] sc, input logic [7:0] fc);
        exp_t e;
        e.name = nm; e.ld = ld; e.fl = fl; e.st = st; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        id_valid = 0; id_sr1 = 0; id_sr2 = 0; id_uses_sr1 = 0; id_uses_sr2 = 0;
        ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0;
        imem_resp = 1; dmem_req = 0; dmem_resp = 0; mem_br_taken = 0; clr_counters = 0;
    endtask

    // LDR R2 in EX, ADD R3,R2,R1 in ID
    task automatic load_use();
        ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_dest = 3'd2;
        id_valid = 1; id_sr1 = 3'd2; id_uses_sr1 = 1; id_sr2 = 3'd1; id_uses_sr2 = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input string what, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s %s: got %0h expected %0h", nm, what, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.name, "loads", {11'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, {11'd0, e.ld});
                cmp(e.name, "flushes", {13'd0, flush_if_id, flush_id_ex, flush_ex_mem}, {13'd0, e.fl});
                cmp(e.name, "state", {14'd0, stall_state}, {14'd0, e.st});
                cmp(e.name, "stall_cycles", stall_cycles, e.sc);
                cmp(e.name, "flush_count", {8'd0, flush_count}, {8'd0, e.fc});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        idle();
        push("reset_init", 5'b00000, 3'b111, RUN, 16'd0, 8'd0);
        #12 reset_n = 1;

        next_cycle(); idle();
        push("idle", 5'b11111, 3'b000, RUN, 16'd0, 8'd0);

        next_cycle(); idle(); load_use();
        push("lu_hazard", 5'b00111, 3'b010, RUN, 16'd0, 8'd0);
        next_cycle(); idle(); load_use();
        push("lu_masked", 5'b11111, 3'b000, LUB, 16'd1, 8'd0);
        next_cycle(); idle();
        push("lu_return", 5'b11111, 3'b000, RUN, 16'd1, 8'd0);

        next_cycle(); idle(); load_use();
        id_sr1 = 3'd1; id_sr2 = 3'd4; id_uses_sr2 = 0; ex_dest = 3'd4;
        push("imm_form", 5'b11111, 3'b000, RUN, 16'd1, 8'd0);
        next_cycle(); idle(); load_use(); ex_reg_write = 0;
        push("no_regwrite", 5'b11111, 3'b000, RUN, 16'd1, 8'd0);
        next_cycle(); idle(); load_use(); id_valid = 0;
        push("id_invalid", 5'b11111, 3'b000, RUN, 16'd1, 8'd0);
        next_cycle(); idle(); load_use(); id_sr1 = 3'd5; id_sr2 = 3'd2;
        push("lu_sr2", 5'b00111, 3'b010, RUN, 16'd1, 8'd0);
        next_cycle(); idle();
        push("lu_sr2_after", 5'b11111, 3'b000, LUB, 16'd2, 8'd0);

        next_cycle(); idle(); imem_resp = 0;
        push("imiss", 5'b01111, 3'b100, RUN, 16'd2, 8'd0);

        for (int i = 0; i < 5; i++) begin
            next_cycle(); idle(); dmem_req = 1; dmem_resp = (i == 4);
            if (i < 4)
                push("dmiss", 5'b00000, 3'b000, (i == 0) ? RUN : DMW, 16'(3 + i), 8'd0);
            else
                push("dmiss_resp", 5'b11111, 3'b000, DMW, 16'd7, 8'd0);
        end
        next_cycle(); idle();
        push("dmiss_done", 5'b11111, 3'b000, RUN, 16'd7, 8'd0);

        next_cycle(); idle(); load_use(); mem_br_taken = 1; imem_resp = 0;
        push("br_imiss_lu", 5'b11111, 3'b111, RUN, 16'd7, 8'd0);
        next_cycle(); idle();
        push("br_count", 5'b11111, 3'b000, RUN, 16'd7, 8'd1);

        next_cycle(); idle(); load_use();
        push("lu_then_br", 5'b00111, 3'b010, RUN, 16'd7, 8'd1);
        next_cycle(); idle(); load_use(); mem_br_taken = 1;
        push("br_in_bubble", 5'b11111, 3'b111, LUB, 16'd8, 8'd1);
        next_cycle(); idle();
        push("br_in_bubble_after", 5'b11111, 3'b000, RUN, 16'd8, 8'd2);

        next_cycle(); idle(); load_use();
        push("lu_then_dmem", 5'b00111, 3'b010, RUN, 16'd8, 8'd2);
        next_cycle(); idle(); dmem_req = 1;
        push("dmem_in_bubble", 5'b00000, 3'b000, LUB, 16'd9, 8'd2);
        next_cycle(); idle();
        push("dmem_in_bubble_after", 5'b11111, 3'b000, DMW, 16'd10, 8'd2);

        next_cycle(); idle(); clr_counters = 1;
        push("clr", 5'b11111, 3'b000, RUN, 16'd10, 8'd2);
        next_cycle(); idle(); clr_counters = 1; imem_resp = 0;
        push("clr_vs_inc", 5'b01111, 3'b100, RUN, 16'd0, 8'd0);
        next_cycle(); idle();
        push("clr_done", 5'b11111, 3'b000, RUN, 16'd0, 8'd0);

        next_cycle(); idle(); dmem_req = 1;
        push("pre_reset_1", 5'b00000, 3'b000, RUN, 16'd0, 8'd0);
        next_cycle(); idle(); dmem_req = 1;
        push("pre_reset_2", 5'b00000, 3'b000, DMW, 16'd1, 8'd0);
        next_cycle(); idle(); dmem_req = 1;
        #2 reset_n = 0;
        push("reset_mid_stall", 5'b00000, 3'b111, RUN, 16'd0, 8'd0);
        @(negedge clk); #2 reset_n = 1; idle();
        next_cycle(); idle();
        push("post_reset", 5'b11111, 3'b000, RUN, 16'd0, 8'd0);

        next_cycle(); idle(); dmem_req = 1;
        push("sat_start", 5'b00000, 3'b000, RUN, 16'd0, 8'd0);
        repeat (65534) @(posedge clk);
        next_cycle(); idle(); dmem_req = 1;
        push("sat_reach", 5'b00000, 3'b000, DMW, 16'hFFFF, 8'd0);
        next_cycle(); idle(); dmem_req = 1;
        push("sat_hold", 5'b00000, 3'b000, DMW, 16'hFFFF, 8'd0);
        next_cycle(); idle(); clr_counters = 1;
        push("sat_clr", 5'b11111, 3'b000, DMW, 16'hFFFF, 8'd0);
        next_cycle(); idle();
        push("sat_cleared", 5'b11111, 3'b000, RUN, 16'd0, 8'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
